nova_ddr_axi4_responder: RTL
============================

// Module: nova_ddr_axi4_responder
// PURPOSE
//  AXI4 responder (slave) for the nova_subsystem DDR_AXI4 master port; the responder end of that interface.
//  Backs the port with an on-chip 512-bit-wide memory.
//  Replaces sh_ddr channel A in simulation and in DDR-less builds.
//  Independent write (AW/W/B) and read (AR/R) engines; one burst in flight per direction.
// PARAMETERS
//  DATA_W     512   data width, bits; byte strobes = DATA_W/8
//  ID_W       16    AXI ID width
//  ADDR_W     64    AXI address width
//  MEM_WORDS  4096  memory depth in DATA_W words (power of 2)
// PORTS
//  clk          in   1        clock (clk_main_a0 at the CL top)
//  rst_n        in   1        asynchronous active-low reset
//  s_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address
//  s_awvalid    in   1  ;  s_awready  out  1
//  s_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data
//  s_wvalid     in   1  ;  s_wready   out  1
//  s_bid/bresp  out  ID_W/2   write response
//  s_bvalid     out  1  ;  s_bready   in   1
//  s_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address
//  s_arvalid    in   1  ;  s_arready  out  1
//  s_rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data
//  s_rvalid     out  1  ;  s_rready   in   1
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs go to IDLE. Memory contents are NOT cleared.
//  Reset asserted mid-burst aborts the burst; no B or R is emitted for it.
//  Word index = addr[log2(DATA_W/8) +: log2(MEM_WORDS)].
//  Size and addr bits below 64B alignment are ignored: every beat is a full word.
//  OOR (out of range): any addr bit above the index field set -> DECERR.
//   OOR writes are dropped. OOR reads return rdata=0. Beats are still counted.
//  Burst: INCR (01) index+1 per beat, wraps modulo MEM_WORDS.
//   FIXED (00) keeps the same index. WRAP (10) is treated as INCR.
//   11 -> SLVERR with no memory access.
//  Write FSM:
//   W_IDLE: awready=1. On AW handshake latch id/index/len/burst, beat=0 -> W_DATA.
//   W_DATA: wready=1. On W handshake write bytes where wstrb=1 (if no error), beat++.
//    At beat==len -> W_RESP (termination on count, not on wlast).
//    wlast != (beat==len) on any beat sets a sticky SLVERR flag.
//   W_RESP: bvalid=1, bid=latched id. bresp = DECERR > SLVERR > OKAY (priority).
//    Hold until bready -> W_IDLE.
//  Read FSM:
//   R_IDLE: arready=1. On AR handshake latch fields -> R_FETCH.
//   R_FETCH: RAM read issued; rvalid=0 -> R_DATA next cycle.
//   R_DATA: rvalid=1; rdata/rid/rresp/rlast held stable until rready.
//    rlast = (beat==len). On handshake: last -> R_IDLE, else beat++, index advance -> R_FETCH.
//   Throughput is 1 beat / 2 cycles; first-beat latency is 2 cycles after AR handshake.
//  Simultaneous write and read of the same word in one cycle: read-first (read returns old data).
//  AW and AR may be accepted in the same cycle; the engines are fully independent.
//  awready=0 outside W_IDLE; arready=0 outside R_IDLE. No combinational valid->ready paths.
// STRUCTURE
//  Package nova_ddr_pkg:
//   - resp_e: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
//   - burst_e: FIXED, INCR, WRAP, RSVD
//   - wr_state_e {W_IDLE, W_DATA, W_RESP}
//   - rd_state_e {R_IDLE, R_FETCH, R_DATA}
//   - next_index() helper
//  Sub-module nova_sdp_ram:
//   - one write port with per-byte enables, one registered read port, read-first
//   - DATA_W x MEM_WORDS
// TESTING
//  1. INCR write awaddr=0x40, awlen=3, data k=0..3 -> bresp=OKAY.
//     Then read the same burst -> 4 beats equal to the written data, rlast on beat 3 only.
//  2. wstrb=64'h0000_0000_0000_00FF over a word pre-filled with 0xAA
//     -> read shows the new low 8 bytes, the other bytes stay 0xAA.
//  3. awaddr = MEM_WORDS*64 -> bresp=DECERR, memory unchanged.
//     araddr at the same address, arlen=1 -> 2 beats of rdata=0, rresp=DECERR.
//  4. Write with wlast asserted on beat 1 of awlen=3
//     -> 4 beats still accepted, bresp=SLVERR.
//     Same test with burst=11 -> SLVERR, no write.
//  5. Hold rready=0 for 10 cycles in R_DATA -> rvalid and rdata stable throughout.
//     Concurrent AW+AR in one cycle -> both accepted; read of an untouched word returns old data.
//  6. Assert rst_n low mid-burst in each FSM -> all outputs 0 asynchronously.
//     After release: idle, memory retained.

Source files
------------

// File: rtl/nova_ddr_pkg.sv
// Purpose : shared types and helpers for the nova DDR AXI4 responder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: AXI response/burst encodings, engine state enums, index and
//           response helpers used by the top and its RAM.
package nova_ddr_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_BURST_W = 2;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  // Word index for the next beat. WRAP is deliberately handled like INCR;
  // the mask gives modulo-depth wrap for a power-of-two memory.
  function automatic logic [31:0] next_index(input logic [31:0] idx,
                                             input logic [1:0]  burst,
                                             input logic [31:0] mask);
    if (burst == FIXED) return idx;
    return (idx + 32'd1) & mask;
  endfunction

  // Decode error outranks slave error, which outranks OKAY.
  function automatic resp_e resp_sel(input logic decerr, input logic slverr);
    if (decerr) return DECERR;
    if (slverr) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/nova_sdp_ram.sv
// Purpose : simple dual-port RAM, one byte-enabled write port, one registered read port.
// Latency : read data valid the cycle after re; read-first on a same-word write.
// Backpressure: none; rdata holds its last value while re is low.
// Ports   : clk; we/waddr/wdata/wstrb write port; re/raddr read request; rdata registered output.
module nova_sdp_ram #(
  parameter int DATA_W    = 512,
  parameter int MEM_WORDS = 4096,
  parameter int IDX_W     = $clog2(MEM_WORDS),
  parameter int STRB_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents are intentionally not reset. Both ports share one block so the
  // non-blocking update gives read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nova_ddr_axi4_responder.sv
// Purpose : AXI4 responder backing the DDR_AXI4 master port with on-chip memory.
// Latency : write B one cycle after the last W beat; first R beat two cycles after AR, then 1 beat / 2 cycles.
// Backpressure: one burst in flight per direction; B and R held stable until bready/rready.
// Ports   : clk, rst_n (async active-low); AXI4 slave channels AW/W/B and AR/R (s_* prefix).
module nova_ddr_axi4_responder
  import nova_ddr_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ID_W      = 16,
  parameter int ADDR_W    = 64,
  parameter int MEM_WORDS = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // write address
  input  logic [ID_W-1:0]        s_awid,
  input  logic [ADDR_W-1:0]      s_awaddr,
  input  logic [7:0]             s_awlen,
  input  logic [2:0]             s_awsize,
  input  logic [1:0]             s_awburst,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  // write data
  input  logic [DATA_W-1:0]      s_wdata,
  input  logic [DATA_W/8-1:0]    s_wstrb,
  input  logic                   s_wlast,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  // write response
  output logic [ID_W-1:0]        s_bid,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  // read address
  input  logic [ID_W-1:0]        s_arid,
  input  logic [ADDR_W-1:0]      s_araddr,
  input  logic [7:0]             s_arlen,
  input  logic [2:0]             s_arsize,
  input  logic [1:0]             s_arburst,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  // read data
  output logic [ID_W-1:0]        s_rid,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic                   s_rvalid,
  input  logic                   s_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [31:0] IDX_MASK = 32'(MEM_WORDS - 1);

  // Per-direction burst context captured at the address handshake.
  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [IDX_W-1:0]       idx;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_LEN_W-1:0]   beat;
    logic [AXI_BURST_W-1:0] burst;
    logic                   decerr;  // address above the memory window
    logic                   rsvd;    // burst type 11
  } ctx_t;

  // ---------------- write engine ----------------
  wr_state_e w_state_q, w_state_d;
  ctx_t      w_ctx_q, w_ctx_d;
  logic      w_proto_q, w_proto_d;   // sticky wlast/count disagreement
  logic      awready_q, awready_d;
  logic      wready_q, wready_d;
  logic      bvalid_q, bvalid_d;

  logic        aw_hs, w_hs, b_hs, aw_oor, w_is_last, ram_we;
  logic [31:0] w_nxt;

  // Readies and valids are flops derived from the next state, so no input
  // valid ever reaches an output ready combinationally.
  assign aw_hs     = s_awvalid & awready_q;
  assign w_hs      = s_wvalid & wready_q;
  assign b_hs      = bvalid_q & s_bready;
  assign aw_oor    = |s_awaddr[ADDR_W-1:OFF_W+IDX_W];
  assign w_is_last = (w_ctx_q.beat == w_ctx_q.len);
  assign w_nxt     = next_index(32'(w_ctx_q.idx), w_ctx_q.burst, IDX_MASK);

  always_comb begin
    w_state_d = w_state_q;
    w_ctx_d   = w_ctx_q;
    w_proto_d = w_proto_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_ctx_d.id     = s_awid;
          w_ctx_d.idx    = s_awaddr[OFF_W +: IDX_W];
          w_ctx_d.len    = s_awlen;
          w_ctx_d.beat   = '0;
          w_ctx_d.burst  = s_awburst;
          w_ctx_d.decerr = aw_oor;
          w_ctx_d.rsvd   = (s_awburst == RSVD);
          w_proto_d      = 1'b0;
          w_state_d      = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          ram_we = ~w_ctx_q.decerr & ~w_ctx_q.rsvd;
          if (s_wlast != w_is_last) w_proto_d = 1'b1;
          // The burst ends on the beat count; wlast only feeds the error flag.
          if (w_is_last) begin
            w_state_d = W_RESP;
          end else begin
            w_ctx_d.beat = w_ctx_q.beat + 8'd1;
            w_ctx_d.idx  = w_nxt[IDX_W-1:0];
          end
        end
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_ctx_q   <= '0;
      w_proto_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_ctx_q   <= w_ctx_d;
      w_proto_q <= w_proto_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bid     = w_ctx_q.id;
  assign s_bresp   = resp_sel(w_ctx_q.decerr, w_ctx_q.rsvd | w_proto_q);

  // ---------------- read engine ----------------
  rd_state_e r_state_q, r_state_d;
  ctx_t      r_ctx_q, r_ctx_d;
  logic      arready_q, arready_d;
  logic      rvalid_q, rvalid_d;

  logic              ar_hs, r_hs, ar_oor, r_is_last, r_mem_ok, ram_re;
  logic [31:0]       r_nxt;
  logic [DATA_W-1:0] ram_rdata;

  assign ar_hs     = s_arvalid & arready_q;
  assign r_hs      = rvalid_q & s_rready;
  assign ar_oor    = |s_araddr[ADDR_W-1:OFF_W+IDX_W];
  assign r_is_last = (r_ctx_q.beat == r_ctx_q.len);
  assign r_mem_ok  = ~r_ctx_q.decerr & ~r_ctx_q.rsvd;
  assign r_nxt     = next_index(32'(r_ctx_q.idx), r_ctx_q.burst, IDX_MASK);

  always_comb begin
    r_state_d = r_state_q;
    r_ctx_d   = r_ctx_q;
    ram_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_ctx_d.id     = s_arid;
          r_ctx_d.idx    = s_araddr[OFF_W +: IDX_W];
          r_ctx_d.len    = s_arlen;
          r_ctx_d.beat   = '0;
          r_ctx_d.burst  = s_arburst;
          r_ctx_d.decerr = ar_oor;
          r_ctx_d.rsvd   = (s_arburst == RSVD);
          r_state_d      = R_FETCH;
        end
      end
      R_FETCH: begin
        // The RAM output register only moves here, which keeps rdata
        // stable for the whole R_DATA stall regardless of writes.
        ram_re    = r_mem_ok;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_is_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_ctx_d.beat = r_ctx_q.beat + 8'd1;
            r_ctx_d.idx  = r_nxt[IDX_W-1:0];
            r_state_d    = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_ctx_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_ctx_q   <= r_ctx_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Payload is gated by rvalid so the (unreset) RAM register never leaks
  // out during reset, and error bursts return zero data.
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rid     = r_ctx_q.id;
  assign s_rdata   = (rvalid_q & r_mem_ok) ? ram_rdata : '0;
  assign s_rlast   = rvalid_q & r_is_last;
  assign s_rresp   = rvalid_q ? resp_sel(r_ctx_q.decerr, r_ctx_q.rsvd) : OKAY;

  // ---------------- storage ----------------
  nova_sdp_ram #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W),
    .STRB_W    (STRB_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_ctx_q.idx),
    .wdata (s_wdata),
    .wstrb (s_wstrb),
    .re    (ram_re),
    .raddr (r_ctx_q.idx),
    .rdata (ram_rdata)
  );

  // Sub-word address bits, size, and the high half of the index helper
  // result carry no information for a full-word memory.
  logic unused_ok;
  assign unused_ok = ^{s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0], s_awsize, s_arsize,
                       w_nxt[31:IDX_W], r_nxt[31:IDX_W]};

endmodule
